// File: rtl/mn_pair_accum.sv
// Sums FRAME_LEN (M+N) pairs per frame and offers the total to downstream with valid/ready.
// Defining MN_PAIR_ACCUM_SEQ_CHECK_EN adds a sticky check that SE counts 0,1,2,3,0,... within a frame.
module mn_pair_accum #(
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] M,
  input  logic [3:0] N,
  input  logic [1:0] SE,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] sum,
  output logic       seq_err
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [8:0] acc_q, acc_d;
  logic [8:0] sum_q, sum_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] pair_sum;
  logic       xfer;
  logic       frame_start;

  assign pair_sum  = {1'b0, M} + {1'b0, N};
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign xfer      = in_valid && in_ready;
  assign sum       = sum_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACC;
          frame_start = 1'b1;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_d = acc_q + {4'b0, pair_sum};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            sum_d   = acc_d;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A start seen on the handshake cycle chains straight into the next frame.
        if (out_ready) begin
          if (start) begin
            state_d     = ACC;
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_start) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

`ifdef MN_PAIR_ACCUM_SEQ_CHECK_EN
  logic [1:0] exp_se_q, exp_se_d;
  logic       seq_err_q, seq_err_d;

  always_comb begin
    exp_se_d  = exp_se_q;
    seq_err_d = seq_err_q;
    if (frame_start) begin
      exp_se_d  = '0;
      seq_err_d = 1'b0;
    end else if (xfer) begin
      exp_se_d = exp_se_q + 2'd1;
      if (SE != exp_se_q) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_se_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_se_q  <= exp_se_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_se;
  assign unused_se = ^SE;
  assign seq_err   = 1'b0;
`endif

endmodule
